// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares one sync-read RAM port among clear (P0), move/judge (P1) and LED scan (P2).
// P0 has fixed top priority, P1/P2 round-robin, bounded locked bursts, one-cycle read return.
module board_ram_arbiter #(
    parameter int ADDR_BITS = 6,
    parameter int DATA_BITS = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               req_i,
    input  logic [2:0]               lock_i,
    input  logic [2:0]               we_i,
    input  logic [3*ADDR_BITS-1:0]   addr_i,
    input  logic [3*DATA_BITS-1:0]   wdata_i,
    output logic [2:0]               gnt_o,
    output logic [2:0]               rvalid_o,
    output logic [DATA_BITS-1:0]     rdata_o,
    output logic                     ram_we_o,
    output logic [ADDR_BITS-1:0]     ram_addr_o,
    output logic [DATA_BITS-1:0]     ram_wdata_o,
    input  logic [DATA_BITS-1:0]     ram_rdata_i,
    output logic                     busy_o
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    typedef enum logic {ARB, BURST} state_t;

    state_t               state_q, state_d;
    logic [1:0]           owner_q, owner_d, win;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc, nc;
    logic                 rr_q, rr_d;
    logic [2:0]           rvalid_q, rvalid_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 any, preempt, stay;

    always_comb begin
        preempt     = state_q == BURST && owner_q != 2'd0 && req_i[0];
        // rr_q=1 means P2 is offered first
        win         = (req_i[0] && (state_q == ARB || preempt)) ? 2'd0 :
                      state_q == BURST ? owner_q :
                      rr_q ? (req_i[2] ? 2'd2 : 2'd1) : (req_i[1] ? 2'd1 : 2'd2);
        any         = rst_n && (state_q == ARB ? |req_i : req_i[win]);
        gnt_o       = any ? 3'b001 << win : 3'b000;
        cnt_inc     = cnt_q == MAXC ? cnt_q : cnt_q + CW'(1);
        nc          = state_q == ARB ? CW'(1) : cnt_inc;
        // P0 bursts are unlimited; P1/P2 release once the beat count reaches MAX_BURST
        stay        = any && !preempt && lock_i[win] && !(win != 2'd0 && nc >= MAXC);
        state_d     = stay ? BURST : ARB;
        owner_d     = stay ? win : owner_q;
        cnt_d       = stay ? nc : '0;
        rr_d        = (any && win != 2'd0) ? win == 2'd1 : rr_q;
        ram_we_o    = any && we_i[win];
        ram_addr_o  = any ? addr_i[win*ADDR_BITS +: ADDR_BITS] : addr_q;
        ram_wdata_o = any ? wdata_i[win*DATA_BITS +: DATA_BITS] : wdata_q;
        rvalid_d    = gnt_o & ~we_i;
        rvalid_o    = rvalid_q;
        rdata_o     = |rvalid_q ? ram_rdata_i : '0;
        busy_o      = state_q == BURST && !preempt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            owner_q  <= '0;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            rvalid_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            rvalid_q <= rvalid_d;
            addr_q   <= ram_addr_o;
            wdata_q  <= ram_wdata_o;
        end
    end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter: directed scenarios against a transaction-level arbitration model,
// checked every cycle, plus literal grant sequences that pin the model.
module tb_board_ram_arbiter;
    localparam int MAXB = 8;

    typedef struct packed {
        logic       we;
        logic       lk;
        logic [5:0] a;
        logic [1:0] d;
    } txn_t;

    logic        clk, rst_n;
    logic [2:0]  req, lock, we;
    logic [17:0] addr;
    logic [5:0]  wdata;
    logic [2:0]  gnt, rvalid;
    logic [1:0]  rdata, ram_wdata, ram_rdata;
    logic        ram_we, busy, mem_init;
    logic [5:0]  ram_addr;
    logic [1:0]  mem [64];

    txn_t q0[$], q1[$], q2[$];
    int   glog[$], rlog[$], eq[$];
    logic [2:0] gs;
    logic p0_we, p0_busy;
    int   checks = 0, failures = 0;

    board_ram_arbiter #(.ADDR_BITS(6), .DATA_BITS(2), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .busy_o(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // synchronous-read board RAM
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 9) ? 2'b01 : 2'(i % 3);
        end else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string nm);
        chk({nm, "_len"}, glog.size(), eq.size());
        for (int i = 0; i < eq.size() && i < glog.size(); i++) chk(nm, glog[i], eq[i]);
    endtask

    task automatic push(input int p, input logic w, input logic l, input logic [5:0] a, input logic [1:0] d);
        txn_t t;
        t = '{we: w, lk: l, a: a, d: d};
        if (p == 0) q0.push_back(t);
        else if (p == 1) q1.push_back(t);
        else q2.push_back(t);
    endtask

    task automatic set_port(input int p, input logic v, input txn_t t);
        req[p]         = v;
        lock[p]        = v & t.lk;
        we[p]          = v & t.we;
        addr[p*6 +: 6] = t.a;
        wdata[p*2 +: 2] = t.d;
    endtask

    // requesters hold each transaction until they see its grant
    initial begin
        txn_t t, z;
        z = '0;
        req = 0; lock = 0; we = 0; addr = 0; wdata = 0;
        forever begin
            @(posedge clk); #1;
            if (gs[0] && q0.size() > 0) t = q0.pop_front();
            if (gs[1] && q1.size() > 0) t = q1.pop_front();
            if (gs[2] && q2.size() > 0) t = q2.pop_front();
            set_port(0, q0.size() > 0, q0.size() > 0 ? q0[0] : z);
            set_port(1, q1.size() > 0, q1.size() > 0 ? q1[0] : z);
            set_port(2, q2.size() > 0, q2.size() > 0 ? q2[0] : z);
        end
    end

    // model: bo = burst owner (-1 none), bn = beats so far, pref = P1/P2 offered first
    initial begin
        int bo, bn, pref, pend, w;
        logic [5:0] la;
        logic [1:0] lw, pdata;
        logic ebusy, ewe;
        bo = -1; bn = 0; pref = 1; pend = -1; la = 0; lw = 0; pdata = 0; gs = 0;
        forever begin
            @(negedge clk);
            gs = gnt;
            if (gnt != 0) glog.push_back(gnt[0] ? 0 : gnt[1] ? 1 : 2);
            if (rvalid != 0) rlog.push_back((rvalid[1] ? 1 : rvalid[2] ? 2 : 0) * 4 + int'(rdata));
            if (gnt[0]) begin p0_we = ram_we; p0_busy = busy; end
            if (!rst_n) begin
                bo = -1; bn = 0; pref = 1; pend = -1; la = 0; lw = 0;
                chk("rst_gnt", gnt, 0);
                chk("rst_rvalid", rvalid, 0);
                chk("rst_ram_we", ram_we, 0);
                chk("rst_busy", busy, 0);
                chk("rst_ram_addr", ram_addr, 0);
                chk("rst_rdata", rdata, 0);
                continue;
            end
            if (req[0]) w = 0;
            else if (bo > 0) w = req[bo] ? bo : -1;
            else if (bo == 0) w = -1;
            else w = req[pref] ? pref : req[3-pref] ? 3 - pref : -1;
            ebusy = bo != -1 && !(req[0] && bo > 0);
            ewe = w >= 0 && we[w];
            if (w >= 0) begin la = addr[w*6 +: 6]; lw = wdata[w*2 +: 2]; end
            chk("gnt", gnt, w < 0 ? 0 : 1 << w);
            chk("rvalid", rvalid, pend < 0 ? 0 : 1 << pend);
            if (pend >= 0) chk("rdata", rdata, pdata);
            chk("ram_we", ram_we, ewe);
            chk("ram_addr", ram_addr, la);
            if (ewe) chk("ram_wdata", ram_wdata, lw);
            chk("busy", busy, ebusy);
            if (w >= 0 && !we[w]) begin pend = w; pdata = mem[addr[w*6 +: 6]]; end
            else pend = -1;
            if (w == 1) pref = 2;
            else if (w == 2) pref = 1;
            if (w < 0) bo = -1;
            else if (w == bo) begin
                bn++;
                if (!lock[w] || (w > 0 && bn >= MAXB)) bo = -1;
            end else if (bo > 0) bo = -1;
            else begin
                bo = (lock[w] && (w == 0 || MAXB > 1)) ? w : -1;
                bn = 1;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size() > 0 || req != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; failures++;
            $display("FAIL idle_timeout queues=%0d/%0d/%0d", q0.size(), q1.size(), q2.size());
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int c, n;
        rst_n = 0; mem_init = 1;
        repeat (3) @(negedge clk);
        chk("init_gnt", gnt, 0);
        chk("init_ram_addr", ram_addr, 0);
        mem_init = 0;
        #2 rst_n = 1;
        repeat (2) @(posedge clk);

        // P1/P2 alternate, P1 first out of reset
        glog.delete();
        for (int i = 0; i < 3; i++) begin push(1, 0, 0, 6'(1 + i), 0); push(2, 0, 0, 6'(4 + i), 0); end
        wait_idle();
        eq = '{1, 2, 1, 2, 1, 2};
        chk_seq("alt");

        // single P1 read of cell 9 returns 01 one cycle later
        glog.delete(); rlog.delete();
        push(1, 0, 0, 6'd9, 0);
        wait_idle();
        eq = '{1};
        chk_seq("p1_read");
        chk("p1_read_rlen", rlog.size(), 1);
        if (rlog.size() > 0) chk("p1_read_rdata", rlog[0], 1 * 4 + 1);

        // P2 locked for 20 beats: 8 granted, forced release, P1 gets in
        glog.delete();
        push(1, 0, 0, 6'd10, 0);
        for (int i = 0; i < 20; i++) push(2, 0, 1, 6'(20 + i), 0);
        wait_idle();
        eq.delete();
        for (int i = 0; i < 8; i++) eq.push_back(2);
        eq.push_back(1);
        for (int i = 0; i < 12; i++) eq.push_back(2);
        chk_seq("burst_limit");

        // P0 preempts a P1 burst after three beats
        glog.delete();
        for (int i = 0; i < 6; i++) push(1, 0, 1, 6'(30 + i), 0);
        n = 0; c = 0;
        while (c < 3 && n < 100) begin
            @(posedge clk);
            n++; c = 0;
            foreach (glog[i]) if (glog[i] == 1) c++;
        end
        chk("preempt_wait", c >= 3, 1);
        push(0, 1, 0, 6'd0, 2'b00);
        wait_idle();
        eq = '{1, 1, 1, 0, 1, 1, 1};
        chk_seq("preempt");
        chk("preempt_ram_we", p0_we, 1);
        chk("preempt_busy", p0_busy, 0);

        // P0 clears the whole board as one unlimited burst, P2 waits
        glog.delete();
        for (int i = 0; i < 64; i++) push(0, 1, i < 63, 6'(i), 2'b00);
        push(2, 1, 0, 6'd5, 2'b10);
        wait_idle();
        eq.delete();
        for (int i = 0; i < 64; i++) eq.push_back(0);
        eq.push_back(2);
        chk_seq("clear");
        @(negedge clk);
        chk("clear_mem9", mem[9], 2'b00);
        chk("clear_mem63", mem[63], 2'b00);
        chk("p2_write_mem5", mem[5], 2'b10);

        // reset right after a P1 read grant: the read never returns
        push(1, 0, 0, 6'd5, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt[1] && n < 20);
        chk("rst_read_granted", gnt[1], 1);
        #2 rst_n = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_drop_rvalid", rvalid, 0);
        end
        chk("rst_drop_rdata", rdata, 0);
        #2 rst_n = 1;
        repeat (2) @(posedge clk);

        // round-robin pointer back at P1 after reset
        glog.delete();
        push(2, 0, 0, 6'd1, 0);
        push(1, 0, 0, 6'd2, 0);
        wait_idle();
        eq = '{1, 2};
        chk_seq("post_rst_rr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1);
    end
endmodule
